// File: rtl/spu_regfile_dp.sv
// SPU dual-write general-purpose register file with parametric read ports,
// same-cycle write forwarding and a hardware clear sequencer.
module spu_regfile_dp #(
  parameter int WIDTH         = 128,
  parameter int REGBITS       = 7,
  parameter int NUM_RD        = 6,
  parameter int CLR_PER_CYCLE = 4,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        we0,
  input  logic [REGBITS-1:0]          wa0,
  input  logic [WIDTH-1:0]            wd0,
  input  logic                        we1,
  input  logic [REGBITS-1:0]          wa1,
  input  logic [WIDTH-1:0]            wd1,
  input  logic [NUM_RD*REGBITS-1:0]   ra,
  output logic [NUM_RD*WIDTH-1:0]     rd,
  input  logic                        clr_req,
  output logic                        busy
);

  localparam int DEPTH = 1 << REGBITS;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]         state;
  logic [REGBITS-1:0] ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               last;
  logic               wr0_ok;
  logic               wr1_ok;
  logic [REGBITS-1:0] rsel;

  assign last = (ptr == REGBITS'(DEPTH - CLR_PER_CYCLE));
  assign busy = (state == CLEAR);

  // Register 0 suppression applies equally to commit and forwarding.
  assign wr0_ok = we0 && (state == IDLE) &&
                  !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && (state == IDLE) &&
                  !((ZERO_REG != 0) && (wa1 == '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          if (last) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + REGBITS'(CLR_PER_CYCLE);
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        for (int i = 0; i < CLR_PER_CYCLE; i++) begin
          mem[ptr + REGBITS'(i)] <= '0;
        end
      end else begin
        if (wr0_ok) mem[wa0] <= wd0;
        if (wr1_ok) mem[wa1] <= wd1;
      end
    end
  end

  always_comb begin
    rd   = '0;
    rsel = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rsel = ra[j*REGBITS +: REGBITS];
      if ((state == IDLE) &&
          !((ZERO_REG != 0) && (rsel == '0))) begin
        if ((BYPASS != 0) && wr1_ok && (wa1 == rsel))
          rd[j*WIDTH +: WIDTH] = wd1;
        else if ((BYPASS != 0) && wr0_ok && (wa0 == rsel))
          rd[j*WIDTH +: WIDTH] = wd0;
        else
          rd[j*WIDTH +: WIDTH] = mem[rsel];
      end
    end
  end

endmodule

// File: tb/tb_spu_regfile_dp.sv
// Directed bench for spu_regfile_dp: default instance plus a
// BYPASS=0 / ZERO_REG=0 instance driven by the same stimulus.
module tb_spu_regfile_dp;

  localparam int W  = 128;
  localparam int RB = 7;
  localparam int NR = 6;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            we0, we1, clr_req;
  logic [RB-1:0]   wa0, wa1;
  logic [W-1:0]    wd0, wd1;
  logic [NR*RB-1:0] ra;
  logic [NR*W-1:0] rd, rd1;
  logic            busy, busy1;

  int nvec = 0;
  int nerr = 0;
  int cnt;

  logic [W-1:0] pa5, ones, v10, v5;

  spu_regfile_dp dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .clr_req(clr_req), .busy(busy)
  );

  spu_regfile_dp #(.BYPASS(0), .ZERO_REG(0)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd1),
    .clr_req(clr_req), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rp(input int j);
    return rd[j*W +: W];
  endfunction

  function automatic logic [W-1:0] rp1(input int j);
    return rd1[j*W +: W];
  endfunction

  task automatic setra(input int j, input int a);
    ra[j*RB +: RB] = RB'(a);
  endtask

  task automatic count_busy(input string tag);
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    chk(tag, W'(cnt), W'(32));
  endtask

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < 128; r++) begin
      setra(r % NR, r);
      #1;
      chk(tag, rp(r % NR), '0);
    end
  endtask

  initial begin
    pa5  = {16{8'hA5}};
    ones = '1;
    v10  = {4{32'h1010_CAFE}};
    v5   = {4{32'h5555_0001}};
    reset_n = 1'b0;
    we0 = 0; we1 = 0; clr_req = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;

    tick();
    chk("rst_busy", W'(busy), W'(1));
    chk("rst_rd0", rp(0), '0);
    tick();
    tick();
    reset_n = 1'b1;
    count_busy("rst_len");
    read_all_zero("init_zero");

    // same-cycle forwarding, then commit
    ra = '0;
    we0 = 1; wa0 = 7'd5; wd0 = pa5;
    setra(0, 5);
    #1;
    chk("byp_same", rp(0), pa5);
    chk("nobyp_same", rp1(0), '0);
    tick();
    we0 = 0;
    #1;
    chk("byp_next", rp(0), pa5);
    chk("nobyp_next", rp1(0), pa5);

    // collision: odd pipe wins
    we0 = 1; wa0 = 7'd9; wd0 = W'(1);
    we1 = 1; wa1 = 7'd9; wd1 = W'(2);
    setra(0, 9);
    #1;
    chk("coll_same", rp(0), W'(2));
    tick();
    we0 = 0; we1 = 0;
    #1;
    chk("coll_next", rp(0), W'(2));
    chk("coll_next1", rp1(0), W'(2));

    // register 0
    we1 = 1; wa1 = '0; wd1 = ones;
    ra = '0;
    #1;
    for (int j = 0; j < NR; j++) chk("r0_same", rp(j), '0);
    chk("r0_same_nz", rp1(0), '0);
    tick();
    we1 = 0;
    #1;
    for (int j = 0; j < NR; j++) chk("r0_next", rp(j), '0);
    chk("r0_next_nz", rp1(0), ones);

    // six ports, two writes hitting two of them
    setra(0, 5); setra(1, 9); setra(2, 10);
    setra(3, 11); setra(4, 12); setra(5, 0);
    we0 = 1; wa0 = 7'd10; wd0 = v10;
    we1 = 1; wa1 = 7'd5;  wd1 = v5;
    #1;
    chk("six_p0", rp(0), v5);
    chk("six_p1", rp(1), W'(2));
    chk("six_p2", rp(2), v10);
    chk("six_p3", rp(3), '0);
    chk("six_p4", rp(4), '0);
    chk("six_p5", rp(5), '0);
    chk("six_nb0", rp1(0), pa5);
    chk("six_nb5", rp1(5), ones);
    tick();
    we0 = 0; we1 = 0;
    #1;
    chk("six_c0", rp(0), v5);
    chk("six_c2", rp(2), v10);

    // fill 1..127 with their own address
    for (int r = 1; r < 128; r += 2) begin
      we0 = 1; wa0 = RB'(r); wd0 = W'(r);
      we1 = (r + 1 < 128); wa1 = RB'(r + 1); wd1 = W'(r + 1);
      tick();
    end
    we0 = 0; we1 = 0;
    setra(0, 100); setra(1, 127); setra(2, 1);
    #1;
    chk("fill100", rp(0), W'(100));
    chk("fill127", rp(1), W'(127));
    chk("fill1", rp(2), W'(1));

    // clear request with a coincident write
    clr_req = 1;
    we0 = 1; wa0 = 7'd3; wd0 = W'(16'h3333);
    tick();
    clr_req = 0;
    wa0 = 7'd50; wd0 = W'(32'hDEAD_BEEF);
    setra(0, 100); setra(1, 50);
    #1;
    chk("clr_busy", W'(busy), W'(1));
    chk("clr_rd", rp(0), '0);
    chk("clr_nobyp", rp(1), '0);
    count_busy("clr_len");
    we0 = 0;
    read_all_zero("clr_zero");

    // reset in the middle of a clear
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 10; k++) tick();
    reset_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_busy", W'(busy), W'(1));
    reset_n = 1'b1;
    count_busy("mid_rst_len");
    chk("mid_rst_busy1", W'(busy1), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spu_regfile_dp.md
# spu_regfile_dp

Dual-issue SPU general-purpose register file: 128 x 128-bit GPRs with two write ports (even/odd pipe writeback), a parametrised number of combinational read ports, optional same-cycle write-to-read bypass, and a hardware clear sequencer run at reset or on request. It sits between SPU decode (operand fetch) and the two writeback stages, replacing the single-write, two-read file.

## Interface
- WIDTH, 128, register width in bits
- REGBITS, 7, address width; DEPTH = 1<<REGBITS registers
- NUM_RD, 6, number of read ports (3 operands x 2 pipes)
- CLR_PER_CYCLE, 4, registers zeroed per clear cycle; power of two, divides DEPTH
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see committed state only
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary GPR
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- we0  in  1  write enable, port 0 (even pipe)
- wa0  in  REGBITS  write address, port 0
- wd0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (odd pipe)
- wa1  in  REGBITS  write address, port 1
- wd1  in  WIDTH  write data, port 1
- ra  in  NUM_RD*REGBITS  read addresses; port j at bits [j*REGBITS +: REGBITS]
- rd  out  NUM_RD*WIDTH  read data; port j at bits [j*WIDTH +: WIDTH]
- clr_req  in  1  pulse: start full-file clear
- busy  out  1  clear sequence in progress

## Operation
- FSM states: IDLE, CLEAR. Registers: state, clear pointer ptr (REGBITS bits), storage array.
- Reset (reset_n low at edge): state <= CLEAR, ptr <= 0. Held low: stays CLEAR with ptr at 0; storage contents not otherwise touched.
- CLEAR: each edge zeroes registers ptr..ptr+CLR_PER_CYCLE-1, ptr <= ptr+CLR_PER_CYCLE; on the edge clearing the last group (ptr = DEPTH-CLR_PER_CYCLE) go IDLE, ptr <= 0. Clear takes DEPTH/CLR_PER_CYCLE edges.
- IDLE: clr_req=1 at edge -> CLEAR, ptr <= 0. clr_req ignored while in CLEAR (no restart).
- busy = (state == CLEAR), registered.
- While busy: we0/we1 ignored (writes dropped); all rd ports return 0; bypass disabled. Upstream stalls issue on busy.
- IDLE writes: on edge, weN=1 stores wdN at waN. If ZERO_REG and waN==0, write dropped.
- Write collision: we0 & we1 & wa0==wa1 -> port 1 data stored (odd pipe is the younger instruction).
- Reads (IDLE, combinational): rd_j = 0 if ZERO_REG and ra_j==0; else if BYPASS and we1 and wa1==ra_j -> wd1; else if BYPASS and we0 and wa0==ra_j -> wd0; else stored value. Bypass follows the same port-1 priority and the same zero-reg suppression as commit.
- Read ports independent; any number may address the same register.

## Timing
- Read latency 0: rd valid combinationally from ra in same cycle.
- Write latency 1: committed at rising edge; visible through storage from next cycle; visible same cycle only via bypass (BYPASS=1).
- busy: 1 from first reset edge until DEPTH/CLR_PER_CYCLE edges after reset_n rises; with defaults, 32 cycles. After clr_req accepted: busy rises next cycle, stays 32 cycles.
- Reset values: busy=1, rd=0 (all ports) from first reset edge.
- reset_n asserted mid-clear: ptr restarts at 0; full clear length again after release.
- clr_req and write in same IDLE edge: write commits, then clear zeroes it.

## Test plan
- Reset 3 cycles, release -> busy=1 for exactly 32 cycles, then 0; read all 128 registers via rd ports -> all 0.
- IDLE: we0 wa0=5 wd0=0xA5..A5, ra[0]=5 same cycle -> rd[0]=0xA5..A5 (BYPASS=1); next cycle we0=0, rd[0] still 0xA5..A5; with BYPASS=0 same-cycle rd[0]=0 (old value).
- Collision: we0 wa0=9 wd0=1, we1 wa1=9 wd1=2 -> same-cycle rd for reg 9 = 2; next cycle stored = 2.
- Register 0: we1 wa1=0 wd1=0xFF..FF -> all ports reading 0 return 0 same and next cycle (ZERO_REG=1); with ZERO_REG=0 returns 0xFF..FF next cycle.
- Write regs 1..127 with value = address; pulse clr_req -> busy 32 cycles, writes during busy dropped, rd=0 during busy; afterwards all registers 0.
- Six ports read six distinct registers while both write ports hit two of them -> each rd matches bypass/priority rules; reassert reset_n at cycle 10 of a clear -> busy lasts 32 cycles after release.
